// File: rtl/axi_write_response_tracker_pkg.sv
// Shared definitions for the stream-to-AXI write path: BRESP codes, tracker FSM
// encodings and the burst length agreed with the adapter.
package axi_write_response_tracker_pkg;

    // The adapter issues AxLEN = AXI_BEATS_PER_BURST-1 on every burst.
    localparam int AXI_BEATS_PER_BURST = 16;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACTIVE = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // SLVERR and DECERR both have bit 1 set; EXOKAY counts as success.
    function automatic logic resp_is_error(input logic [1:0] resp);
        return resp[1];
    endfunction

endpackage

// File: rtl/axi_outstanding_counter.sv
// Up/down count of bursts accepted on AW but not yet acknowledged on B, with a
// flag raised once the configured limit is reached.
module axi_outstanding_counter #(
    parameter int WIDTH = 4,
    parameter int LIMIT = 8
) (
    input  logic i_aclk,
    input  logic i_resetn,
    input  logic i_clear,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_at_limit
);

    logic [WIDTH-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_aclk) begin
        if (!i_resetn || i_clear) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            r_count <= r_count + 1'b1;
        end else if (i_dec && !i_inc) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_at_limit = (r_count >= WIDTH'(LIMIT));

endmodule

// File: rtl/axi_write_response_tracker.sv
// Tracks AW bursts against B responses for one transfer and gates AW to a bounded
// outstanding depth. Optional BID checking: define AXI_WRITE_RESPONSE_TRACKER_ID_CHECK_EN.
module axi_write_response_tracker
    import axi_write_response_tracker_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 8,
    parameter int BEATS_PER_BURST = AXI_BEATS_PER_BURST,
    parameter int MAX_OUTSTANDING = 8,
    parameter int EXPECTED_ID     = 0
) (
    input  logic                  aclk,
    input  logic                  resetn,
    input  logic                  s_cmd_valid,
    input  logic [ADDR_WIDTH-1:0] s_cmd_beats,
    output logic                  s_cmd_ready,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    input  logic [ID_WIDTH-1:0]   m_bid,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  done,
    output logic                  error,
    output logic [1:0]            errorResp,
    output logic                  busy
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int SHIFT = $clog2(BEATS_PER_BURST);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_total;
    logic [CNT_W-1:0] r_issued;
    logic [CNT_W-1:0] r_received;
    logic             r_error;
    logic [1:0]       r_error_resp;

    logic             w_active;
    logic             w_cmd_fire;
    logic             w_at_limit;
    logic             w_aw_gate;
    logic             w_aw_fire;
    logic             w_b_fire;
    logic             w_resp_err;
    logic             w_id_err;
    logic [CNT_W-1:0] w_total_calc;
    logic [CNT_W-1:0] w_received_next;

    // One extra bit so a max-length beat count rounds up without wrapping.
    assign w_total_calc = ({1'b0, s_cmd_beats} + CNT_W'(BEATS_PER_BURST - 1)) >> SHIFT;

    assign w_active    = (r_state == ST_ACTIVE);
    // NOTE: gated by resetn so the command port reads not-ready for the whole reset window.
    assign s_cmd_ready = resetn && (r_state == ST_IDLE);
    assign w_cmd_fire  = s_cmd_valid && s_cmd_ready;

    assign w_aw_gate = w_active && !w_at_limit && (r_issued < r_total);
    assign m_awvalid = s_awvalid && w_aw_gate;
    assign s_awready = m_awready && w_aw_gate;
    assign w_aw_fire = s_awvalid && m_awready && w_aw_gate;

    assign m_bready        = w_active && (r_received < r_total);
    assign w_b_fire        = m_bvalid && m_bready;
    assign w_received_next = r_received + CNT_W'(w_b_fire);
    assign w_resp_err      = w_b_fire && resp_is_error(m_bresp);

`ifdef AXI_WRITE_RESPONSE_TRACKER_ID_CHECK_EN
    assign w_id_err = w_b_fire && (m_bid != ID_WIDTH'(EXPECTED_ID));
`else
    logic w_unused_bid;
    assign w_unused_bid = ^m_bid;
    assign w_id_err     = 1'b0;
`endif

    axi_outstanding_counter #(
        .WIDTH (OUT_W),
        .LIMIT (MAX_OUTSTANDING)
    ) u_outstanding (
        .i_aclk     (aclk),
        .i_resetn   (resetn),
        .i_clear    (w_cmd_fire),
        .i_inc      (w_aw_fire),
        .i_dec      (w_b_fire),
        .o_at_limit (w_at_limit)
    );

    always_ff @(posedge aclk) begin
        if (!resetn) begin
            r_state      <= ST_IDLE;
            r_total      <= '0;
            r_issued     <= '0;
            r_received   <= '0;
            r_error      <= 1'b0;
            r_error_resp <= RESP_OKAY;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_fire) begin
                        r_total      <= w_total_calc;
                        r_issued     <= '0;
                        r_received   <= '0;
                        r_error      <= 1'b0;
                        r_error_resp <= RESP_OKAY;
                        r_state      <= ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (w_aw_fire) r_issued <= r_issued + 1'b1;
                    if (w_b_fire) r_received <= w_received_next;
                    if (w_resp_err || w_id_err) r_error <= 1'b0 | 1'b1;
                    // An ID-only error leaves errorResp at OKAY until a real BRESP error arrives.
                    if (w_resp_err && !r_error_resp[1]) r_error_resp <= m_bresp;
                    if (w_received_next == r_total) r_state <= ST_DONE;
                end
                ST_DONE:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign done      = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign error     = r_error;
    assign errorResp = r_error_resp;

endmodule

// File: tb/tb_axi_write_response_tracker.sv
// Directed bench for axi_write_response_tracker: table of transfers against a
// responsive memory model, plus throttle, reset and BID sequences.
module tb_axi_write_response_tracker;

    localparam int ADDR_WIDTH = 32;
    localparam int ID_WIDTH   = 8;
    localparam int MAX_OUT    = 2;
    localparam int NVEC       = 8;

    logic                  aclk;
    logic                  resetn;
    logic                  s_cmd_valid;
    logic [ADDR_WIDTH-1:0] s_cmd_beats;
    logic                  s_cmd_ready;
    logic                  s_awvalid;
    logic                  s_awready;
    logic                  m_awvalid;
    logic                  m_awready;
    logic [ID_WIDTH-1:0]   m_bid;
    logic [1:0]            m_bresp;
    logic                  m_bvalid;
    logic                  m_bready;
    logic                  done;
    logic                  error;
    logic [1:0]            errorResp;
    logic                  busy;

    axi_write_response_tracker #(
        .ADDR_WIDTH      (ADDR_WIDTH),
        .ID_WIDTH        (ID_WIDTH),
        .BEATS_PER_BURST (16),
        .MAX_OUTSTANDING (MAX_OUT),
        .EXPECTED_ID     (0)
    ) dut (
        .aclk        (aclk),
        .resetn      (resetn),
        .s_cmd_valid (s_cmd_valid),
        .s_cmd_beats (s_cmd_beats),
        .s_cmd_ready (s_cmd_ready),
        .s_awvalid   (s_awvalid),
        .s_awready   (s_awready),
        .m_awvalid   (m_awvalid),
        .m_awready   (m_awready),
        .m_bid       (m_bid),
        .m_bresp     (m_bresp),
        .m_bvalid    (m_bvalid),
        .m_bready    (m_bready),
        .done        (done),
        .error       (error),
        .errorResp   (errorResp),
        .busy        (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        logic [31:0] beats;
        logic [15:0] resp_map;   // 2 bits of BRESP per burst index 0..7
        int          exp_bursts;
        logic        exp_err;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_pass   = 0;

    // memory model / scoreboard state
    int          aw_cnt, b_cnt, pending, max_pend, credits;
    logic [15:0] resp_map;
    logic [7:0]  tb_bid;

    // values sampled on the falling edge
    logic smp_aw_fire, smp_b_fire, smp_done, smp_cmd_ready, smp_cmd_fire;
    logic smp_err, smp_awvalid, smp_s_awready, smp_bready, smp_busy;
    logic [1:0] smp_resp;

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic drive_b();
        m_bvalid = (pending > 0) && (credits > 0);
        m_bresp  = (b_cnt < 8) ? resp_map[2*b_cnt +: 2] : 2'b00;
        m_bid    = tb_bid;
    endtask

    task automatic cycle();
        @(negedge aclk);
        smp_aw_fire   = m_awvalid && m_awready;
        smp_b_fire    = m_bvalid && m_bready;
        smp_done      = done;
        smp_cmd_ready = s_cmd_ready;
        smp_cmd_fire  = s_cmd_valid && s_cmd_ready;
        smp_err       = error;
        smp_resp      = errorResp;
        smp_awvalid   = m_awvalid;
        smp_s_awready = s_awready;
        smp_bready    = m_bready;
        smp_busy      = busy;
        @(posedge aclk);
        #1;
        if (smp_aw_fire) begin aw_cnt++; pending++; end
        if (smp_b_fire) begin b_cnt++; pending--; credits--; end
        if (pending > max_pend) max_pend = pending;
        drive_b();
    endtask

    task automatic start_cmd(input logic [31:0] beats, input logic [15:0] map, input int cred);
        resp_map    = map;
        credits     = cred;
        aw_cnt      = 0;
        b_cnt       = 0;
        max_pend    = 0;
        s_cmd_valid = 1'b1;
        s_cmd_beats = beats;
        s_awvalid   = 1'b1;
        m_awready   = 1'b1;
        drive_b();
    endtask

    task automatic run_transfer(input string name, input logic [31:0] beats, input logic [15:0] map,
                                input int exp_bursts, input logic exp_err, input logic [1:0] exp_resp);
        int acc_cyc, done_cyc, last_b_cyc, pulses;
        logic err_at_done, rdy_after;
        logic [1:0] resp_at_done;
        acc_cyc = -1; done_cyc = -1; last_b_cyc = -1; pulses = 0;
        err_at_done = 1'b0; resp_at_done = 2'b00; rdy_after = 1'b0;
        start_cmd(beats, map, 1000);
        for (int c = 0; c < 200; c++) begin
            cycle();
            if (smp_cmd_fire) begin acc_cyc = c; s_cmd_valid = 1'b0; end
            if (smp_b_fire) last_b_cyc = c;
            if (smp_done) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c; err_at_done = smp_err; resp_at_done = smp_resp;
                end
            end
            if (done_cyc >= 0 && c == done_cyc + 1) rdy_after = smp_cmd_ready;
            if (done_cyc >= 0 && c >= done_cyc + 2) break;
        end
        s_cmd_valid = 1'b0;
        check({name, "_aw_count"}, aw_cnt, exp_bursts);
        check({name, "_b_count"}, b_cnt, exp_bursts);
        if (exp_bursts == 0) check({name, "_done_after_accept"}, done_cyc - acc_cyc, 2);
        else                 check({name, "_done_after_last_b"}, done_cyc - last_b_cyc, 1);
        check({name, "_done_pulses"}, pulses, 1);
        check({name, "_error"}, err_at_done, exp_err);
        check({name, "_errorResp"}, resp_at_done, exp_resp);
        check({name, "_ready_after_done"}, rdy_after, 1);
        check({name, "_outstanding_bound"}, (max_pend <= MAX_OUT) ? 1 : 0, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic id_exp_err;
        bit   done_seen;

        vecs[0] = '{32'd64, 16'h0000, 4, 1'b0, 2'b00};
        vecs[1] = '{32'd17, 16'h0000, 2, 1'b0, 2'b00};
        vecs[2] = '{32'd48, 16'h0038, 3, 1'b1, 2'b10};
        vecs[3] = '{32'd1,  16'h0000, 1, 1'b0, 2'b00};
        vecs[4] = '{32'd16, 16'h0000, 1, 1'b0, 2'b00};
        vecs[5] = '{32'd0,  16'h0000, 0, 1'b0, 2'b00};
        vecs[6] = '{32'd33, 16'h0001, 3, 1'b0, 2'b00};
        vecs[7] = '{32'd32, 16'h000B, 2, 1'b1, 2'b11};

        resetn = 1'b0; s_cmd_valid = 1'b0; s_cmd_beats = '0;
        s_awvalid = 1'b1; m_awready = 1'b1;
        tb_bid = 8'd0; resp_map = '0; credits = 0; pending = 0;
        aw_cnt = 0; b_cnt = 0; max_pend = 0;
        drive_b();

        repeat (3) cycle();
        check("rst_cmd_ready", smp_cmd_ready, 0);
        check("rst_m_awvalid", smp_awvalid, 0);
        check("rst_s_awready", smp_s_awready, 0);
        check("rst_m_bready", smp_bready, 0);
        check("rst_done", smp_done, 0);
        check("rst_error", smp_err, 0);
        check("rst_errorResp", smp_resp, 0);
        check("rst_busy", smp_busy, 0);
        resetn = 1'b1;
        cycle();
        check("rst_release_cmd_ready", smp_cmd_ready, 1);

        for (int i = 0; i < NVEC; i++)
            run_transfer($sformatf("vec%0d", i), vecs[i].beats, vecs[i].resp_map,
                         vecs[i].exp_bursts, vecs[i].exp_err, vecs[i].exp_resp);

        // Throttle: B held back, AW must stall at the outstanding limit.
        start_cmd(32'd96, 16'h0000, 0);
        cycle();
        check("thr_accept", smp_cmd_fire, 1);
        s_cmd_valid = 1'b0;
        repeat (6) cycle();
        check("thr_aw_at_limit", aw_cnt, 2);
        check("thr_awvalid_blocked", smp_awvalid, 0);
        check("thr_busy", smp_busy, 1);
        credits = 1; drive_b();
        repeat (4) cycle();
        check("thr_one_b", b_cnt, 1);
        check("thr_one_more_aw", aw_cnt, 3);
        check("thr_awvalid_blocked2", smp_awvalid, 0);
        m_awready = 1'b0; credits = 1; drive_b();
        repeat (3) cycle();
        check("thr_b_awready_low", b_cnt, 2);
        check("thr_awvalid_open", smp_awvalid, 1);
        m_awready = 1'b1; credits = 1; drive_b();
        cycle();
        check("thr_simultaneous", {smp_aw_fire, smp_b_fire}, 3);
        repeat (3) cycle();
        check("thr_aw_after_simul", aw_cnt, 5);
        check("thr_awvalid_after_simul", smp_awvalid, 0);
        credits = 100; drive_b();
        done_seen = 0;
        for (int c = 0; c < 50 && !done_seen; c++) begin
            cycle();
            if (smp_done) done_seen = 1;
        end
        check("thr_done", done_seen, 1);
        check("thr_all_b", b_cnt, 6);
        check("thr_all_aw", aw_cnt, 6);
        cycle();

        // Reset in the middle of a transfer with an error already latched.
        start_cmd(32'd80, 16'h0002, 1);
        cycle();
        check("mid_accept", smp_cmd_fire, 1);
        s_cmd_valid = 1'b0;
        repeat (8) cycle();
        check("mid_aw_before_reset", aw_cnt, 3);
        check("mid_error_before_reset", smp_err, 1);
        resetn = 1'b0;
        cycle();
        pending = 0; credits = 0; drive_b();
        cycle();
        check("mid_rst_cmd_ready", smp_cmd_ready, 0);
        check("mid_rst_m_awvalid", smp_awvalid, 0);
        check("mid_rst_m_bready", smp_bready, 0);
        check("mid_rst_error", smp_err, 0);
        check("mid_rst_errorResp", smp_resp, 0);
        check("mid_rst_busy", smp_busy, 0);
        resetn = 1'b1;
        cycle();
        check("mid_release_cmd_ready", smp_cmd_ready, 1);
        run_transfer("post_reset", 32'd16, 16'h0000, 1, 1'b0, 2'b00);

        // BID mismatch: flags an error only when the ID check is built in.
`ifdef AXI_WRITE_RESPONSE_TRACKER_ID_CHECK_EN
        id_exp_err = 1'b1;
`else
        id_exp_err = 1'b0;
`endif
        tb_bid = 8'd1;
        run_transfer("bid_mismatch", 32'd32, 16'h0000, 2, id_exp_err, 2'b00);
        tb_bid = 8'd0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_write_response_tracker.md
# axi_write_response_tracker

Sits on the AXI side of the stream-to-AXI write adapter. Counts the write bursts that leave the adapter's address channel and collects the matching B-channel responses. Signals transfer completion only once every burst of a transfer is acknowledged by memory. Throttles the AW channel to a bounded number of outstanding bursts and reports the first error response of a transfer.

## Interface
Parameters:
- ADDR_WIDTH, 32, width of beat-count command
- ID_WIDTH, 8, width of BID
- BEATS_PER_BURST, 16, beats per AXI burst; must match the adapter (AxLEN 15 + 1), power of two
- MAX_OUTSTANDING, 8, maximum AW-accepted-but-not-B-acknowledged bursts, 1..255
- EXPECTED_ID, 0, BID value expected on every response (used only with ID check)

Ports:
- aclk  in  1  clock, all logic on rising edge
- resetn  in  1  synchronous active-low reset
- s_cmd_valid  in  1  new transfer announced (driven alongside the adapter's s_avalid)
- s_cmd_beats  in  ADDR_WIDTH  transfer length in beats
- s_cmd_ready  out  1  tracker idle, command accepted on valid&&ready
- s_awvalid  in  1  AW valid from adapter
- s_awready  out  1  AW ready to adapter
- m_awvalid  out  1  AW valid to memory
- m_awready  in  1  AW ready from memory
- m_bid  in  ID_WIDTH  response ID
- m_bresp  in  2  response code
- m_bvalid  in  1  response valid
- m_bready  out  1  response ready
- done  out  1  one-cycle pulse, all bursts acknowledged
- error  out  1  sticky for current transfer, non-OKAY or ID mismatch seen
- errorResp  out  2  first offending BRESP (2'b00 if ID mismatch only)
- busy  out  1  transfer in flight

## Operation
- State machine IDLE → ACTIVE → DONE → IDLE.
- IDLE: s_cmd_ready=1. On s_cmd_valid: burstsTotal = (s_cmd_beats + BEATS_PER_BURST-1) / BEATS_PER_BURST, computed in ADDR_WIDTH+1 bits (no overflow at max beats). Clear issued, received, outstanding, error, errorResp. Go ACTIVE.
- ACTIVE:
  - m_awvalid = s_awvalid && outstanding < MAX_OUTSTANDING && issued < burstsTotal; s_awready = m_awready under the same gate. Combinational, no added latency on AW; AW payload does not pass through this block.
  - AW handshake: issued+1, outstanding+1.
  - m_bready = received < burstsTotal. B handshake: received+1, outstanding−1.
  - AW and B handshake in the same cycle: outstanding unchanged.
  - B handshake with bresp[1]=1 (SLVERR/DECERR): if error clear, set error and latch errorResp. EXOKAY treated as OKAY.
  - When received == burstsTotal (registered compare): go DONE.
  - burstsTotal = 0 (zero beats): no AW passes, DONE next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. error/errorResp hold until next command accept.
- Outside ACTIVE: m_awvalid=0, s_awready=0, m_bready=0. Stray B beats are not accepted.
- busy = state != IDLE.

## Timing
- Reset values: s_cmd_ready=0 during reset, 1 the first cycle after resetn rises. m_awvalid, s_awready, m_bready, done, error, busy=0. errorResp=2'b00.
- Reset mid-transfer: all counters cleared and state IDLE. No response draining; system-level reset of the memory side is required.
- Command accept → ACTIVE next cycle. AW may pass one cycle after the accept edge.
- Last B handshake at cycle N: DONE state and done=1 at N+1, s_cmd_ready=1 at N+2.
- outstanding never exceeds MAX_OUTSTANDING. received never exceeds issued.

## Configuration
- AXI_WRITE_RESPONSE_TRACKER_ID_CHECK_EN defined: every B handshake with m_bid != EXPECTED_ID sets error (errorResp keeps first BRESP error, else 00). The response is still counted.
- Not defined: m_bid is ignored entirely; no ID logic is synthesized.

## Structure
- Shared package: BRESP codes (OKAY, EXOKAY, SLVERR, DECERR), state enum, BEATS_PER_BURST constant shared with the stream-to-AXI adapter.
- One sub-module: axi_outstanding_counter (up/down counter with limit flag and simultaneous inc/dec handling).

## Test plan
- beats=64, m_awready and m_bvalid always 1, OKAY: exactly 4 AW handshakes, 4 B accepted, done one cycle after 4th B, error=0.
- beats=17: burstsTotal=2. Third AW attempt blocked (m_awvalid=0).
- MAX_OUTSTANDING=2, beats=80, B held low: m_awvalid drops after 2 AW. One B releases exactly one more AW. Simultaneous AW+B keeps outstanding=2.
- beats=48, second B = SLVERR, third B = DECERR: error=1, errorResp=2'b10, done still after third B.
- beats=0: done pulse 2 cycles after command accept, no AW passed.
- Reset asserted with 3 outstanding: all outputs at reset values next cycle. New command after reset completes normally. With ID check enabled, bid=EXPECTED_ID+1 yields error=1, errorResp=00.
